// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU and the blocks that drive it:
// opcode encoding, opcode legality check, flag bundle and default latency.
package alu_pkg;

  // Default number of ALU edges from operand sample to registered result
  localparam int ALU_LAT_DEF = 2;

  // ALU opcode encoding; bit 3 selects the subtract / arithmetic-shift variants
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  // Flag bundle as produced by the ALU, packed MSB-first as {v,z,n,c,cout}
  typedef struct packed {
    logic v;
    logic z;
    logic n;
    logic c;
    logic cout;
  } alu_flags_t;

  // True for the ten opcodes the ALU implements; everything else is rejected
  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Initiator for the registered ALU. Takes one command at a time over a
// valid/ready channel, presents registered operands to the ALU, waits out the
// ALU latency, captures result and flags and hands them back with the tag.
// Illegal opcodes never reach the ALU; they are answered immediately with an
// error response.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_res,
  input  logic             alu_v,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_res,
  output logic [4:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Latency counter is loaded with ALU_LAT+1 so the capture edge lands one
  // edge after the ALU output register has taken the new operands' result.
  localparam int                LCNT_W   = $clog2(ALU_LAT + 2);
  localparam logic [LCNT_W-1:0] LAT_LOAD = LCNT_W'(ALU_LAT + 1);
  localparam logic [LCNT_W-1:0] LAT_ONE  = LCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e             state_r;
  state_e             state_nxt_s;
  logic [LCNT_W-1:0]  lat_cnt_r;
  logic               accept_s;
  logic               legal_s;
  logic               lat_done_s;
  logic               rsp_fire_s;
  alu_flags_t         flags_s;

  logic [31:0]        alu_a_r;
  logic [31:0]        alu_b_r;
  logic [3:0]         alu_op_r;
  logic               rsp_valid_r;
  logic [31:0]        rsp_res_r;
  logic [4:0]         rsp_flags_r;
  logic [TAG_W-1:0]   rsp_tag_r;
  logic               rsp_err_r;
  logic [CNT_W-1:0]   issue_cnt_r;
  logic [CNT_W-1:0]   err_cnt_r;

  // All outputs except cmd_ready come straight from flops
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_res   = rsp_res_r;
  assign rsp_flags = rsp_flags_r;
  assign rsp_tag   = rsp_tag_r;
  assign rsp_err   = rsp_err_r;
  assign issue_cnt = issue_cnt_r;
  assign err_cnt   = err_cnt_r;

  // Command decode and flag bundling
  always_comb begin
    legal_s         = op_legal(cmd_op);
    accept_s        = cmd_valid & cmd_ready;
    lat_done_s      = (state_r == ST_WAIT) && (lat_cnt_r == LAT_ONE);
    flags_s.v       = alu_v;
    flags_s.z       = alu_z;
    flags_s.n       = alu_n;
    flags_s.c       = alu_c;
    flags_s.cout    = alu_cout;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; RESP can chain straight into the next command
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = legal_s ? ST_WAIT : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_done_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (accept_s) begin
          state_nxt_s = legal_s ? ST_WAIT : ST_RESP;
        end else if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: ready when idle, or when the pending response drains this edge
  always_comb begin
    cmd_ready  = 1'b0;
    rsp_fire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready  = 1'b1;
        rsp_fire_s = 1'b0;
      end
      ST_RESP: begin
        cmd_ready  = rsp_ready;
        rsp_fire_s = rsp_ready;
      end
      default: begin
        cmd_ready  = 1'b0;
        rsp_fire_s = 1'b0;
      end
    endcase
  end

  // Latency counter: loaded on legal issue, counts down while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_r <= '0;
    end else if (accept_s && legal_s) begin
      lat_cnt_r <= LAT_LOAD;
    end else if (state_r == ST_WAIT) begin
      lat_cnt_r <= lat_cnt_r - LAT_ONE;
    end
  end

  // ALU operand registers, held until the next legal command is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_r  <= 32'h0000_0000;
      alu_b_r  <= 32'h0000_0000;
      alu_op_r <= 4'b0000;
    end else if (accept_s && legal_s) begin
      alu_a_r  <= cmd_a;
      alu_b_r  <= cmd_b;
      alu_op_r <= cmd_op;
    end
  end

  // Response registers: error answer on illegal accept, ALU capture at latency end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_res_r   <= 32'h0000_0000;
      rsp_flags_r <= 5'b00000;
      rsp_tag_r   <= '0;
      rsp_err_r   <= 1'b0;
    end else if (accept_s && legal_s) begin
      rsp_valid_r <= 1'b0;
      rsp_tag_r   <= cmd_tag;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_res_r   <= 32'h0000_0000;
      rsp_flags_r <= 5'b00000;
      rsp_tag_r   <= cmd_tag;
      rsp_err_r   <= 1'b1;
    end else if (lat_done_s) begin
      rsp_valid_r <= 1'b1;
      rsp_res_r   <= alu_res;
      rsp_flags_r <= flags_s;
      rsp_err_r   <= 1'b0;
    end else if (rsp_fire_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Statistics counters, wrapping silently at full scale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_r <= '0;
      err_cnt_r   <= '0;
    end else if (accept_s && legal_s) begin
      issue_cnt_r <= issue_cnt_r + CNT_ONE;
    end else if (accept_s) begin
      err_cnt_r   <= err_cnt_r + CNT_ONE;
    end
  end

endmodule
